// File: rtl/seq_cmp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
// Result vectors are one-hot {L, E, H}, matching the slice comparator output order.
package seq_cmp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CMP  = 2'd1;
  localparam state_t DONE = 2'd2;

  typedef logic [2:0] res_t;

  localparam res_t RES_L = 3'b100;
  localparam res_t RES_E = 3'b010;
  localparam res_t RES_H = 3'b001;

  // Width of a slice index; a single-slice build still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slice_cmp.sv
// Combinational CHUNK-bit compare; i_signed treats the operands as two's complement.
module slice_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_signed,
  output logic             o_lt,
  output logic             o_eq,
  output logic             o_gt
);

  logic [CHUNK-1:0] w_a_adj;
  logic [CHUNK-1:0] w_b_adj;

  // Flipping the sign bit maps two's complement onto offset binary, so one
  // unsigned comparator serves both modes.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_a_adj            = i_a;
    w_b_adj            = i_b;
    w_a_adj[CHUNK-1]   = i_a[CHUNK-1] ^ i_signed;
    w_b_adj[CHUNK-1]   = i_b[CHUNK-1] ^ i_signed;
  end

  assign o_eq = (i_a == i_b);
  assign o_lt = (w_a_adj < w_b_adj);
  assign o_gt = (w_a_adj > w_b_adj);

endmodule

// File: rtl/seq_comparator_n_bit.sv
// Multi-cycle MSB-first magnitude comparator with valid/ready on input and result.
// Build option: define EARLY_EXIT_EN to stop at the first differing slice.
module seq_comparator_n_bit
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    a,
  input  logic [WIDTH-1:0]                    b,
  input  logic                                signed_mode,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                l,
  output logic                                e,
  output logic                                h,
  output logic [$clog2(WIDTH/CHUNK+1)-1:0]    slices_used
);

  localparam int NSLICES = WIDTH / CHUNK;
  localparam int IDXW    = idx_width(NSLICES);
  localparam int CNTW    = $clog2(NSLICES + 1);
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NSLICES - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $fatal(1, "seq_comparator_n_bit: WIDTH must be a multiple of CHUNK");
  end

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_signed;
  logic [IDXW-1:0]    r_idx;
  logic [CNTW-1:0]    r_cnt;
  res_t               r_res;
`ifndef EARLY_EXIT_EN
  logic               r_found;
`endif

  logic [CHUNK-1:0]   w_a_sl [NSLICES];
  logic [CHUNK-1:0]   w_b_sl [NSLICES];
  logic               w_lt;
  logic               w_eq;
  logic               w_gt;
  logic               w_slice_signed;
  res_t               w_slice_res;
  logic               w_last;

  for (genvar g = 0; g < NSLICES; g++) begin : g_slices
    assign w_a_sl[g] = r_a[g*CHUNK +: CHUNK];
    assign w_b_sl[g] = r_b[g*CHUNK +: CHUNK];
  end

  // Only the top slice carries the sign bit.
  assign w_slice_signed = r_signed && (r_idx == TOP_IDX);

  slice_cmp #(.CHUNK(CHUNK)) u_slice_cmp (
    .i_a      (w_a_sl[r_idx]),
    .i_b      (w_b_sl[r_idx]),
    .i_signed (w_slice_signed),
    .o_lt     (w_lt),
    .o_eq     (w_eq),
    .o_gt     (w_gt)
  );

  assign w_slice_res = {w_lt, w_eq, w_gt};
  assign w_last      = (r_idx == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_res    <= '0;
`ifndef EARLY_EXIT_EN
      r_found  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= signed_mode;
            r_idx    <= TOP_IDX;
            r_cnt    <= '0;
`ifndef EARLY_EXIT_EN
            r_found  <= 1'b0;
`endif
            r_state  <= CMP;
          end
        end
        CMP: begin
          r_cnt <= r_cnt + 1'b1;
`ifdef EARLY_EXIT_EN
          if (!w_eq || w_last) begin
            r_res   <= w_slice_res;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
`else
          // First decisive slice (or all-equal at slice 0) is kept; later slices are ignored.
          if (!r_found && (!w_eq || w_last)) begin
            r_res   <= w_slice_res;
            r_found <= 1'b1;
          end
          if (w_last) begin
            r_state <= DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign l           = r_res[2];
  assign e           = r_res[1];
  assign h           = r_res[0];
  assign slices_used = r_cnt;

endmodule

// File: tb/tb_seq_comparator_n_bit.sv
// Randomized scoreboard bench for seq_comparator_n_bit; expectations follow EARLY_EXIT_EN.
module tb_seq_comparator_n_bit;

  localparam int WIDTH   = 32;
  localparam int CHUNK   = 8;
  localparam int NSLICES = WIDTH / CHUNK;
  localparam int CNTW    = $clog2(NSLICES + 1);

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              signed_mode;
  logic              out_valid;
  logic              out_ready;
  logic              l;
  logic              e;
  logic              h;
  logic [CNTW-1:0]   slices_used;

  seq_comparator_n_bit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .l           (l),
    .e           (e),
    .h           (h),
    .slices_used (slices_used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic   l;
    logic   e;
    logic   h;
    int     k;
    longint acc;
  } exp_t;

  exp_t   sb_q[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  logic   rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer compare; latency from the highest differing bit.
  function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                                 input logic ts);
    exp_t r;
    longint va, vb;
    logic [WIDTH-1:0] x;
    int msb;
    va = ts ? longint'($signed(ta))   : longint'(ta);
    vb = ts ? longint'($signed(tb_v)) : longint'(tb_v);
    r.l = (va < vb);
    r.e = (va == vb);
    r.h = (va > vb);
    x = ta ^ tb_v;
    msb = -1;
    for (int i = 0; i < WIDTH; i++) if (x[i]) msb = i;
`ifdef EARLY_EXIT_EN
    r.k = (msb < 0) ? NSLICES : NSLICES - (msb / CHUNK);
`else
    r.k = NSLICES;
`endif
    r.acc = 0;
    return r;
  endfunction

  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic ts);
    exp_t x;
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 0, 1);
      return;
    end
    a = ta;
    b = tb_v;
    signed_mode = ts;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    x = model(ta, tb_v, ts);
    x.acc = cyc;
    sb_q.push_back(x);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    signed_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || out_valid || !in_ready) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (sb_q.size() == 0 && !out_valid && in_ready), 1);
  endtask

  // Random consumer backpressure, changed just after the edge.
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops on the first cycle of each result, then checks hold-stability every cycle.
  logic seen = 1'b0;
  logic have = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (rst || !out_valid) begin
      seen = 1'b0;
    end else begin
      if (!seen) begin
        seen = 1'b1;
        if (sb_q.size() == 0) begin
          check("unexpected_result", 1, 0);
          have = 1'b0;
        end else begin
          cur = sb_q.pop_front();
          have = 1'b1;
          check("latency", cyc - cur.acc, cur.k);
        end
      end
      if (have) begin
        check("l", l, cur.l);
        check("e", e, cur.e);
        check("h", h, cur.h);
        check("slices_used", slices_used, cur.k);
        check("in_ready_in_done", in_ready, 0);
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    signed_mode = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_lehf", {l, e, h}, 0);
    check("rst_slices", slices_used, 0);

    // Directed cases, consumer always ready.
    send(32'd22, 32'd200, 1'b0);
    send(32'h1200_0000, 32'h11FF_FFFF, 1'b0);
    send(32'd888, 32'd888, 1'b0);
    send(32'd233, 32'd200, 1'b0);
    send(32'd123, 32'd234, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    send(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    send(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    wait_idle(200);

    // Backpressure: hold the result for 5 cycles while in_valid pulses.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h0000_1234, 32'h0000_1235, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_rise", out_valid, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      check("bp_out_valid_held", out_valid, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_after", in_ready, 1);
    check("bp_out_valid_after", out_valid, 0);

    // Reset two slices into a compare; the transaction must vanish.
    send(32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_lehf", {l, e, h}, 0);
    check("mid_rst_slices", slices_used, 0);
    send(32'd5, 32'd5, 1'b0);
    wait_idle(200);

    // Randomized traffic with random backpressure; half the pairs share upper slices.
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = {ra[WIDTH-1:CHUNK], rb[CHUNK-1:0]};
        2: rb = {ra[WIDTH-1:2*CHUNK], rb[2*CHUNK-1:0]};
        default: ;
      endcase
      send(ra, rb, 1'($urandom_range(0, 1)));
    end
    wait_idle(2000);
    rand_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
